// File: rtl/display_pkg.sv
// Shared constants, field indices, FSM encodings and digit-blanking helpers
// for the clock display BCD path.
package display_pkg;

  localparam int unsigned CONV_W      = 13;
  localparam int unsigned CONV_CYCLES = 13;
  localparam int unsigned NUM_FIELDS  = 6;
  localparam logic [3:0]  BLANK_CODE  = 4'hF;

  typedef enum logic [2:0] {
    FLD_SEC, FLD_MIN, FLD_HOUR, FLD_DAY, FLD_MONT, FLD_YEAR
  } field_e;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  function automatic logic [7:0] blank_tens(input logic [7:0] v);
    blank_tens = v;
    if (v[7:4] == 4'd0) blank_tens[7:4] = BLANK_CODE;
  endfunction

  // Blank leading zeros left to right; units always survive.
  function automatic logic [15:0] blank_year(input logic [15:0] v);
    blank_year = v;
    if (v[15:12] == 4'd0) begin
      blank_year[15:12] = BLANK_CODE;
      if (v[11:8] == 4'd0) begin
        blank_year[11:8] = BLANK_CODE;
        if (v[7:4] == 4'd0) blank_year[7:4] = BLANK_CODE;
      end
    end
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 (double dabble) converter; one bit per non-load cycle.
module bin2bcd_serial
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CONV_W-1:0] din,
  output logic [15:0]       bcd
);

  logic [15:0]       bcd_q, adj;
  logic [CONV_W-1:0] bin_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else if (load) begin
      bcd_q <= '0;
      bin_q <= din;
    end else begin
      bcd_q <= {adj[14:0], bin_q[CONV_W-1]};
      bin_q <= {bin_q[CONV_W-2:0], 1'b0};
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/bcd_field_sched.sv
// Snapshots six time/date fields and converts them one at a time through a
// shared serial converter. Optional leading-zero blanking: BCD_LEAD_BLANK_EN.
module bcd_field_sched
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hour,
  input  logic [4:0]  day,
  input  logic [3:0]  mont,
  input  logic [12:0] year,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  mont_bcd,
  output logic [15:0] year_bcd,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] CNT_LAST = 4'(CONV_CYCLES - 1);

  logic [1:0]        state_q;
  logic [3:0]        cnt_q;
  logic [2:0]        fld_q;
  logic              pending_q;
  logic [CONV_W-1:0] snap_q [NUM_FIELDS];

  logic              start, last, load;
  logic [CONV_W-1:0] din;
  logic [15:0]       res, year_fmt;
  logic [7:0]        tens_fmt;

  assign start = (state_q == IDLE) && (update || pending_q);
  assign last  = (fld_q == FLD_YEAR);
  assign load  = start || ((state_q == WRITE) && !last);

  // sec loads straight from the port on the accepting edge; the rest from the snapshot.
  always_comb begin
    din = CONV_W'(sec);
    if (state_q == WRITE) begin
      case (fld_q)
        FLD_SEC:  din = snap_q[FLD_MIN];
        FLD_MIN:  din = snap_q[FLD_HOUR];
        FLD_HOUR: din = snap_q[FLD_DAY];
        FLD_DAY:  din = snap_q[FLD_MONT];
        FLD_MONT: din = snap_q[FLD_YEAR];
        default:  din = snap_q[FLD_SEC];
      endcase
    end
  end

`ifdef BCD_LEAD_BLANK_EN
  assign tens_fmt = blank_tens(res[7:0]);
  assign year_fmt = blank_year(res);
`else
  assign tens_fmt = res[7:0];
  assign year_fmt = res;
`endif

  bin2bcd_serial u_conv (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .bcd  (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fld_q     <= '0;
      pending_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sec_bcd   <= '0;
      min_bcd   <= '0;
      hour_bcd  <= '0;
      day_bcd   <= '0;
      mont_bcd  <= '0;
      year_bcd  <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) snap_q[i] <= '0;
    end else begin
      done <= 1'b0;
      if (update && (state_q != IDLE)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q[FLD_SEC]  <= CONV_W'(sec);
            snap_q[FLD_MIN]  <= CONV_W'(min);
            snap_q[FLD_HOUR] <= CONV_W'(hour);
            snap_q[FLD_DAY]  <= CONV_W'(day);
            snap_q[FLD_MONT] <= CONV_W'(mont);
            snap_q[FLD_YEAR] <= year;
            pending_q <= 1'b0;
            busy      <= 1'b1;
            fld_q     <= FLD_SEC;
            cnt_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_LAST) state_q <= WRITE;
          else                   cnt_q   <= cnt_q + 4'd1;
        end
        WRITE: begin
          case (fld_q)
            FLD_SEC:  sec_bcd  <= res[7:0];
            FLD_MIN:  min_bcd  <= res[7:0];
            FLD_HOUR: hour_bcd <= tens_fmt;
            FLD_DAY:  day_bcd  <= tens_fmt;
            FLD_MONT: mont_bcd <= tens_fmt;
            default:  year_bcd <= year_fmt;
          endcase
          if (last) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            fld_q   <= fld_q + 3'd1;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_field_sched.sv
// Directed-vector bench for bcd_field_sched; edge 0 is the edge that accepts update.
module tb_bcd_field_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0;
  logic [5:0]  sec = '0, min = '0;
  logic [4:0]  hour = '0, day = '0;
  logic [3:0]  mont = '0;
  logic [12:0] year = '0;
  logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, mont_bcd;
  logic [15:0] year_bcd;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

`ifdef BCD_LEAD_BLANK_EN
  localparam logic [7:0]  EXP_HOUR0 = 8'hF0;
  localparam logic [15:0] EXP_YEAR0 = 16'hFFF0;
  localparam logic [15:0] EXP_YEAR5 = 16'hFFF5;
  localparam logic [7:0]  EXP_HOUR3 = 8'hF3;
  localparam logic [7:0]  EXP_MONT1 = 8'hF1;
`else
  localparam logic [7:0]  EXP_HOUR0 = 8'h00;
  localparam logic [15:0] EXP_YEAR0 = 16'h0000;
  localparam logic [15:0] EXP_YEAR5 = 16'h0005;
  localparam logic [7:0]  EXP_HOUR3 = 8'h03;
  localparam logic [7:0]  EXP_MONT1 = 8'h01;
`endif

  bcd_field_sched dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .day      (day),
    .mont     (mont),
    .year     (year),
    .sec_bcd  (sec_bcd),
    .min_bcd  (min_bcd),
    .hour_bcd (hour_bcd),
    .day_bcd  (day_bcd),
    .mont_bcd (mont_bcd),
    .year_bcd (year_bcd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_fields(input int s, input int mi, input int h, input int d, input int mo,
                            input int y);
    sec  = 6'(s);
    min  = 6'(mi);
    hour = 5'(h);
    day  = 5'(d);
    mont = 4'(mo);
    year = 13'(y);
  endtask

  // Drives update across exactly one edge; that edge is edge 0.
  task automatic pulse_update();
    update = 1'b1;
    tick(1);
    update = 1'b0;
  endtask

  // Clocks until done is seen; returns edges elapsed. Expired budget is a failure.
  task automatic wait_done(input string tag, input int budget, output int edges);
    edges = 0;
    do begin
      tick(1);
      edges++;
    end while (!done && edges < budget);
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: got no done expected done within %0d edges", tag, budget);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] s, input logic [7:0] mi,
                           input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo,
                           input logic [15:0] y);
    check_eq({tag, "_sec"},  32'(sec_bcd),  32'(s));
    check_eq({tag, "_min"},  32'(min_bcd),  32'(mi));
    check_eq({tag, "_hour"}, 32'(hour_bcd), 32'(h));
    check_eq({tag, "_day"},  32'(day_bcd),  32'(d));
    check_eq({tag, "_mont"}, 32'(mont_bcd), 32'(mo));
    check_eq({tag, "_year"}, 32'(year_bcd), 32'(y));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit saw_done;

    // Reset state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check_all("rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    // Test 1: timing of one full sequence
    set_fields(59, 7, 23, 31, 12, 2024);
    pulse_update();
    check_eq("t1_busy_e0", 32'(busy), 32'd1);
    for (int e = 1; e <= 85; e++) begin
      tick(1);
      if (e == 13) check_eq("t1_sec_e13", 32'(sec_bcd), 32'h00);
      if (e == 14) check_eq("t1_sec_e14", 32'(sec_bcd), 32'h59);
      if (e == 27) check_eq("t1_min_e27", 32'(min_bcd), 32'h00);
      if (e == 28) check_eq("t1_min_e28", 32'(min_bcd), 32'h07);
      if (e == 83) begin
        check_eq("t1_busy_e83", 32'(busy), 32'd1);
        check_eq("t1_done_e83", 32'(done), 32'd0);
        check_eq("t1_year_e83", 32'(year_bcd), 32'h0);
      end
      if (e == 84) begin
        check_eq("t1_done_e84", 32'(done), 32'd1);
        check_eq("t1_busy_e84", 32'(busy), 32'd0);
      end
      if (e == 85) check_eq("t1_done_e85", 32'(done), 32'd0);
    end
    check_all("t1", 8'h59, 8'h07, 8'h23, 8'h31, 8'h12, 16'h2024);

    // Test 2: input change after snapshot is ignored
    tick(3);
    set_fields(59, 7, 23, 31, 12, 2024);
    pulse_update();
    tick(5);
    sec = 6'd0;
    wait_done("t2a", 200, n);
    check_eq("t2_done_edge", 32'(n + 5), 32'd84);
    check_eq("t2_sec_snap", 32'(sec_bcd), 32'h59);
    tick(2);
    pulse_update();
    wait_done("t2b", 200, n);
    check_eq("t2_sec_new", 32'(sec_bcd), 32'h00);

    // Test 3: update during busy queues exactly one more sequence
    tick(2);
    set_fields(59, 7, 23, 31, 12, 2024);
    pulse_update();
    tick(39);
    update = 1'b1;
    tick(1);
    update = 1'b0;
    set_fields(30, 45, 12, 15, 10, 1999);
    wait_done("t3a", 200, n);
    check_eq("t3_done1_edge", 32'(n + 40), 32'd84);
    check_all("t3a", 8'h59, 8'h07, 8'h23, 8'h31, 8'h12, 16'h2024);
    tick(1);
    check_eq("t3_busy_e85", 32'(busy), 32'd1);
    check_eq("t3_done_e85", 32'(done), 32'd0);
    wait_done("t3b", 200, n);
    check_eq("t3_done2_edge", 32'(n + 85), 32'd169);
    check_all("t3b", 8'h30, 8'h45, 8'h12, 8'h15, 8'h10, 16'h1999);
    tick(2);
    set_fields(11, 22, 13, 14, 11, 2000);
    pulse_update();
    for (int k = 0; k < 3; k++) begin
      tick(9);
      update = 1'b1;
      tick(1);
      update = 1'b0;
    end
    wait_done("t3c", 200, n);
    wait_done("t3d", 200, n);
    check_eq("t3_merge_edges", 32'(n), 32'd85);
    tick(2);
    check_eq("t3_no_third", 32'(busy), 32'd0);

    // Test 4: boundary values
    set_fields(63, 0, 0, 20, 11, 8191);
    pulse_update();
    wait_done("t4a", 200, n);
    check_all("t4a", 8'h63, 8'h00, EXP_HOUR0, 8'h20, 8'h11, 16'h8191);
    tick(1);
    year = 13'd0;
    pulse_update();
    wait_done("t4b", 200, n);
    check_eq("t4_year0", 32'(year_bcd), 32'(EXP_YEAR0));

    // Test 5: reset mid-sequence with a pending request
    tick(1);
    set_fields(12, 45, 16, 21, 9, 1987);
    pulse_update();
    tick(9);
    update = 1'b1;
    tick(1);
    update = 1'b0;
    tick(19);
    check_eq("t5_min_written", 32'(min_bcd), 32'h45);
    #3;
    rst = 1'b1;
    #1;
    check_all("t5_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    tick(2);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int e = 0; e < 120; e++) begin
      tick(1);
      if (done || busy) saw_done = 1'b1;
    end
    check_eq("t5_pending_lost", 32'(saw_done), 32'd0);
    pulse_update();
    wait_done("t5b", 200, n);
    check_eq("t5_fresh_edge", 32'(n), 32'd84);
    check_eq("t5_fresh_year", 32'(year_bcd), 32'h1987);

    // Test 6: leading-zero blanking (or plain BCD without it)
    tick(1);
    set_fields(4, 0, 3, 10, 1, 5);
    pulse_update();
    wait_done("t6a", 200, n);
    check_all("t6a", 8'h04, 8'h00, EXP_HOUR3, 8'h10, EXP_MONT1, EXP_YEAR5);
    tick(1);
    year = 13'd0;
    pulse_update();
    wait_done("t6b", 200, n);
    check_eq("t6_year0", 32'(year_bcd), 32'(EXP_YEAR0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
